// File: rtl/usb_audio_rate_ctrl_pkg.sv
// Shared constants, state encoding and period helper for the USB audio sample-rate controller.
package usb_audio_rate_ctrl_pkg;

  localparam int unsigned NominalDiv = 1250;
  localparam int unsigned TrimMax    = 4;
  localparam int unsigned FillW      = 10;
  localparam int unsigned FillTarget = 96;
  localparam int unsigned Deadband   = 8;
  localparam int unsigned FullLevel  = 508;
  localparam int unsigned LockFrames = 16;

  localparam int unsigned TrimW   = 4;
  localparam int unsigned PeriodW = 11;
  localparam int unsigned LockW   = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPrime = 2'b01,
    StTrack = 2'b10
  } rate_state_e;

  // Strobe period in clk cycles for a given signed trim.
  function automatic logic [PeriodW-1:0] period_of(logic signed [TrimW-1:0] trim);
    logic signed [PeriodW:0] p;
    p = $signed((PeriodW+1)'(NominalDiv)) + (PeriodW+1)'(trim);
    return p[PeriodW-1:0];
  endfunction

endpackage

// File: rtl/usb_audio_rate_ctrl_if.sv
// Control/status bundle between the USB audio top and the sample-rate controller.
interface usb_audio_rate_ctrl_if;
  import usb_audio_rate_ctrl_pkg::*;

  logic                    run;
  logic                    sof;
  logic [FillW-1:0]        fill;
  logic                    audio_en;
  logic signed [TrimW-1:0] trim;
  rate_state_e             state;
  logic                    locked;
  logic                    underrun;
  logic                    overrun;

  modport master (
    output run, sof, fill,
    input  audio_en, trim, state, locked, underrun, overrun
  );

  modport slave (
    input  run, sof, fill,
    output audio_en, trim, state, locked, underrun, overrun
  );

endinterface

// File: rtl/usb_audio_rate_ctrl_strobe_div.sv
// Sample strobe divider: counts one period, pulses audio_en after the wrap and latches the
// next period from the trim present in the wrap cycle.
module usb_audio_rate_ctrl_strobe_div
  import usb_audio_rate_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [TrimW-1:0] trim,
  output logic                    wrap,
  output logic                    audio_en
);

  logic [PeriodW-1:0] cnt_q, cnt_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic               audio_en_q, audio_en_d;

  assign wrap     = en && (cnt_q == (period_q - PeriodW'(1)));
  assign audio_en = audio_en_q;

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    audio_en_d = 1'b0;
    if (!en) begin
      // Idle: hold at zero with the period primed so tracking starts a full period out.
      cnt_d    = '0;
      period_d = period_of(trim);
    end else if (wrap) begin
      cnt_d      = '0;
      period_d   = period_of(trim);
      audio_en_d = 1'b1;
    end else begin
      cnt_d = cnt_q + PeriodW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      period_q   <= PeriodW'(NominalDiv);
      audio_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      audio_en_q <= audio_en_d;
    end
  end

endmodule

// File: rtl/usb_audio_rate_ctrl.sv
// Adaptive 48 kHz strobe scheduler: primes on buffer fill, servos the period trim once per SOF
// and reports lock, underrun and overrun.
module usb_audio_rate_ctrl
  import usb_audio_rate_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  usb_audio_rate_ctrl_if.slave bus
);

  localparam logic signed [TrimW-1:0]  TrimHi  = TrimW'(TrimMax);
  localparam logic signed [TrimW-1:0]  TrimLo  = -TrimHi;
  localparam logic signed [TrimW-1:0]  TrimOne = TrimW'(1);
  localparam logic signed [FillW:0]    BandHi  = (FillW+1)'(Deadband);
  localparam logic signed [FillW:0]    BandLo  = -BandHi;
  localparam logic signed [FillW:0]    Target  = (FillW+1)'(FillTarget);

  rate_state_e             state_q, state_d;
  logic signed [TrimW-1:0] trim_q, trim_d;
  logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                    locked_q;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;
  logic                    tracking, wrap, audio_en;
  logic signed [FillW:0]   err;
  logic                    in_band;

  assign tracking = (state_q == StTrack) && bus.run;
  assign err      = $signed({1'b0, bus.fill}) - Target;
  assign in_band  = (err <= BandHi) && (err >= BandLo);

  usb_audio_rate_ctrl_strobe_div u_strobe_div (
    .clk      (clk),
    .rst      (rst),
    .en       (tracking),
    .trim     (trim_q),
    .wrap     (wrap),
    .audio_en (audio_en)
  );

  always_comb begin
    state_d    = state_q;
    trim_d     = trim_q;
    lock_cnt_d = lock_cnt_q;
    underrun_d = wrap && (bus.fill == '0);
    overrun_d  = wrap && (bus.fill >= FillW'(FullLevel));
    if (!bus.run) begin
      state_d    = StIdle;
      trim_d     = '0;
      lock_cnt_d = '0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StPrime;
          trim_d  = '0;
        end
        StPrime: begin
          if (bus.sof && (bus.fill >= FillW'(FillTarget))) state_d = StTrack;
        end
        StTrack: begin
          if (bus.sof) begin
            // Too full drains faster (shorter period), too empty drains slower.
            if (err > BandHi) begin
              trim_d = (trim_q == TrimLo) ? trim_q : trim_q - TrimOne;
            end else if (err < BandLo) begin
              trim_d = (trim_q == TrimHi) ? trim_q : trim_q + TrimOne;
            end
            if (!in_band) begin
              lock_cnt_d = '0;
            end else if (lock_cnt_q != LockW'(LockFrames)) begin
              lock_cnt_d = lock_cnt_q + LockW'(1);
            end
          end
          if (underrun_d) begin
            state_d    = StPrime;
            lock_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      trim_q     <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trim_q     <= trim_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (lock_cnt_d == LockW'(LockFrames));
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.audio_en = audio_en;
  assign bus.trim     = trim_q;
  assign bus.state    = state_q;
  assign bus.locked   = locked_q;
  assign bus.underrun = underrun_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_usb_audio_rate_ctrl.sv
// Directed bench for usb_audio_rate_ctrl: a timeline model (absolute strobe deadlines) checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_usb_audio_rate_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  usb_audio_rate_ctrl_if bus ();

  usb_audio_rate_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs after each edge, from the pre-edge inputs. Strobes are scheduled as absolute
  // cycle deadlines rather than a running counter.
  int m_cyc = 0, m_state = 0, m_trim = 0, m_lock = 0, m_next = 0;
  int m_en = 0, m_under = 0, m_over = 0, m_locked = 0;

  initial begin
    int f, pt, err;
    forever begin
      @(posedge clk or posedge rst);
      m_cyc++;
      m_en = 0; m_under = 0; m_over = 0;
      if (rst) begin
        m_state = 0; m_trim = 0; m_lock = 0;
      end else if (!bus.run) begin
        m_state = 0; m_trim = 0; m_lock = 0;
      end else begin
        f   = int'(bus.fill);
        pt  = m_trim;
        err = f - 96;
        case (m_state)
          0: begin m_state = 1; m_trim = 0; end
          1: if (bus.sof && f >= 96) begin m_state = 2; m_next = m_cyc + 1250 + pt; end
          default: begin
            if (m_cyc == m_next) begin
              m_en   = 1;
              m_next = m_cyc + 1250 + pt;
              if (f == 0) begin m_under = 1; m_state = 1; end
              else if (f >= 508) m_over = 1;
            end
            if (bus.sof) begin
              if (err > 8) m_trim = (pt - 1 < -4) ? -4 : pt - 1;
              else if (err < -8) m_trim = (pt + 1 > 4) ? 4 : pt + 1;
              if (err >= -8 && err <= 8) m_lock = (m_lock < 16) ? m_lock + 1 : 16;
              else m_lock = 0;
            end
            if (m_state != 2) m_lock = 0;
          end
        endcase
      end
      m_locked = (m_lock == 16) ? 1 : 0;
    end
  end

  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        t = bus.trim;
        chk("state", int'(bus.state), m_state);
        chk("audio_en", int'(bus.audio_en), m_en);
        chk("trim", t, m_trim);
        chk("locked", int'(bus.locked), m_locked);
        chk("underrun", int'(bus.underrun), m_under);
        chk("overrun", int'(bus.overrun), m_over);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sof();
    bus.sof = 1'b1;
    cycles(1);
    bus.sof = 1'b0;
  endtask

  // Cycles from now until the next audio_en, bounded.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (!bus.audio_en && n < 4000);
    if (n >= 4000) chk("strobe_timeout", n, 0);
  endtask

  int trim_dn[6] = '{-1, -2, -3, -4, -4, -4};
  int trim_up[9] = '{-3, -2, -1, 0, 1, 2, 3, 4, 4};

  initial begin
    int n, seen, t;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.sof = 1'b0;
    bus.fill = '0;
    cycles(3);
    @(negedge clk);
    t = bus.trim;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_audio_en", int'(bus.audio_en), 0);
    chk("rst_trim", t, 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_flags", int'({bus.underrun, bus.overrun}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle with run low
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      cycles(1);
      if (bus.audio_en) seen++;
    end
    t = bus.trim;
    chk("idle_state", int'(bus.state), 0);
    chk("idle_trim", t, 0);
    chk("idle_strobes", seen, 0);

    // 2: prime then track
    bus.run = 1'b1;
    bus.fill = 10'd40;
    cycles(5);
    chk("prime_state", int'(bus.state), 1);
    for (int i = 0; i < 3; i++) begin
      pulse_sof();
      cycles(20);
    end
    chk("prime_hold", int'(bus.state), 1);
    bus.fill = 10'd96;
    pulse_sof();
    chk("track_entry", int'(bus.state), 2);
    wait_strobe(n);
    chk("first_strobe", n, 1250);

    // 3: servo saturation both ways
    bus.fill = 10'd120;
    for (int i = 0; i < 6; i++) begin
      pulse_sof();
      t = bus.trim;
      chk("trim_down", t, trim_dn[i]);
      cycles(49);
    end
    wait_strobe(n);
    wait_strobe(n);
    chk("period_min", n, 1246);
    bus.fill = 10'd70;
    for (int i = 0; i < 9; i++) begin
      pulse_sof();
      t = bus.trim;
      chk("trim_up", t, trim_up[i]);
      cycles(49);
    end

    // 4: lock
    bus.fill = 10'd100;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("lock_at_15", int'(bus.locked), 0);
      pulse_sof();
      cycles(19);
    end
    chk("locked", int'(bus.locked), 1);
    bus.fill = 10'd110;
    pulse_sof();
    chk("unlock", int'(bus.locked), 0);

    // 5: underrun, re-prime, overrun boundary
    wait_strobe(n);
    bus.fill = '0;
    wait_strobe(n);
    chk("underrun", int'(bus.underrun), 1);
    chk("underrun_state", int'(bus.state), 1);
    cycles(10);
    bus.fill = 10'd96;
    pulse_sof();
    chk("retrack", int'(bus.state), 2);
    bus.fill = 10'd507;
    wait_strobe(n);
    chk("retrack_first", n, 1253);
    chk("no_overrun_507", int'(bus.overrun), 0);
    bus.fill = 10'd508;
    wait_strobe(n);
    chk("overrun_508", int'(bus.overrun), 1);
    chk("overrun_state", int'(bus.state), 2);

    // 6: sof coincident with wrap, then run drop
    bus.fill = 10'd110;
    for (int i = 0; i < 3; i++) begin
      pulse_sof();
      cycles(19);
    end
    t = bus.trim;
    chk("trim_zero", t, 0);
    wait_strobe(n);
    cycles(1249);
    pulse_sof();
    t = bus.trim;
    chk("coinc_strobe", int'(bus.audio_en), 1);
    chk("coinc_trim", t, -1);
    wait_strobe(n);
    chk("coinc_next", n, 1250);
    wait_strobe(n);
    chk("coinc_after", n, 1249);
    cycles(600);
    bus.run = 1'b0;
    cycles(1);
    t = bus.trim;
    chk("drop_state", int'(bus.state), 0);
    chk("drop_trim", t, 0);
    seen = 0;
    for (int i = 0; i < 1500; i++) begin
      cycles(1);
      if (bus.audio_en) seen++;
    end
    chk("drop_strobes", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
